// File: rtl/vga_pkg.sv
// Shared raster-timing types, the reference 640x480@60 mode and small helpers
// used to size counters from a timing description.
package vga_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  function automatic int unsigned h_total(vga_timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned v_total(vga_timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle between the timing generator (master) and the pixel source / DAC side
// (slave): request stream out, returned colour in, aligned video out.
interface vga_sync_gen_if
  import vga_pkg::*;
#(
  parameter int unsigned XW = cnt_width(h_total(VGA_640x480_60)),
  parameter int unsigned YW = cnt_width(v_total(VGA_640x480_60)),
  parameter int unsigned CW = 4
);

  logic          en;
  logic          pix_tick;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_req;
  logic [3*CW-1:0] rgb_in;
  logic [CW-1:0] vga_r;
  logic [CW-1:0] vga_g;
  logic [CW-1:0] vga_b;
  logic          hsync;
  logic          vsync;
  logic          vga_visible;
  logic          line_start;
  logic          frame_start;
  logic [15:0]   frame_cnt;

  modport master (
    input  en, rgb_in,
    output pix_tick, pix_x, pix_y, pix_req, vga_r, vga_g, vga_b,
           hsync, vsync, vga_visible, line_start, frame_start, frame_cnt
  );

  modport slave (
    output en, rgb_in,
    input  pix_tick, pix_x, pix_y, pix_req, vga_r, vga_g, vga_b,
           hsync, vsync, vga_visible, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register with asynchronous reset to RST_VAL; DEPTH=0
// degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, adv_i};
    assign q_o       = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset, not only the head, so nothing stale can reach the pins after reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else if (adv_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised raster timing generator: pixel-tick divider, h/v counters,
// request stream, and a sync/blank delay matched to the pixel-source latency.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640x480_60.h_active,
  parameter int unsigned H_FP     = VGA_640x480_60.h_fp,
  parameter int unsigned H_SYNC   = VGA_640x480_60.h_sync,
  parameter int unsigned H_BP     = VGA_640x480_60.h_bp,
  parameter int unsigned V_ACTIVE = VGA_640x480_60.v_active,
  parameter int unsigned V_FP     = VGA_640x480_60.v_fp,
  parameter int unsigned V_SYNC   = VGA_640x480_60.v_sync,
  parameter int unsigned V_BP     = VGA_640x480_60.v_bp,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned CW       = 4
) (
  input logic           clk,
  input logic           rst,
  vga_sync_gen_if.master bus
);

  localparam vga_timing_t TIMING = '{
    h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
  };
  localparam int unsigned H_TOTAL = h_total(TIMING);
  localparam int unsigned V_TOTAL = v_total(TIMING);
  localparam int unsigned XW      = cnt_width(H_TOTAL);
  localparam int unsigned YW      = cnt_width(V_TOTAL);
  localparam int unsigned DW      = cnt_width(CLK_DIV);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      CLK_DIV < 1 || PIPE_LAT > 15) begin : g_bad_cfg
    $error("vga_sync_gen: unsupported timing configuration");
  end

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]   div_q, div_d;
  logic [XW-1:0]   h_q, h_d;
  logic [YW-1:0]   v_q, v_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            tick;
  logic            pix_req;
  logic            hs_raw, vs_raw;
  logic [2:0]      align_dly;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            visible_q, visible_d;
  logic [3*CW-1:0] rgb_q, rgb_d;

  assign tick = bus.en && (div_q == DIV_LAST);

  always_comb begin
    // NOTE: each next-state signal starts from its held value, so no branch can leave it unassigned and infer a latch.
    div_d       = div_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    if (bus.en) div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d         = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          v_d = v_q + YW'(1);
        end
      end else begin
        h_d = h_q + XW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      div_q       <= div_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pix_req = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw  = (h_q >= HS_START && h_q < HS_END) ? H_POL : ~H_POL;
  assign vs_raw  = (v_q >= VS_START && v_q < VS_END) ? V_POL : ~V_POL;

  // Sync and blank wait here for the colour the source returns PIPE_LAT ticks later.
  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_LAT),
    .RST_VAL ({~H_POL, ~V_POL, 1'b0})
  ) u_align (
    .clk   (clk),
    .rst   (rst),
    .adv_i (tick),
    .d_i   ({hs_raw, vs_raw, pix_req}),
    .q_o   (align_dly)
  );

  always_comb begin
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    visible_d = visible_q;
    rgb_d     = rgb_q;
    if (tick) begin
      hsync_d   = align_dly[2];
      vsync_d   = align_dly[1];
      visible_d = align_dly[0];
      rgb_d     = align_dly[0] ? bus.rgb_in : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q   <= ~H_POL;
      vsync_q   <= ~V_POL;
      visible_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      visible_q <= visible_d;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.pix_tick    = tick;
  assign bus.pix_x       = h_q;
  assign bus.pix_y       = v_q;
  assign bus.pix_req     = pix_req;
  assign bus.line_start  = tick && (h_q == '0);
  assign bus.frame_start = tick && (h_q == '0) && (v_q == '0);
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.vga_visible = visible_q;
  assign {bus.vga_r, bus.vga_g, bus.vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen in a 15x8 mode (CLK_DIV=2, PIPE_LAT=2,
// active-low syncs) with a 2-tick echoing pixel source.
module tb_vga_sync_gen;

  localparam int unsigned XW = 4;
  localparam int unsigned YW = 3;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;

  vga_sync_gen_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0),
    .CLK_DIV(2), .PIPE_LAT(2), .CW(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_t      = 0;   // ticks completed since reset
  int m_div    = 0;
  bit src_mode = 1'b0; // 0: echo {x,y}; 1: constant white

  // Pixel source: answers a request two ticks later.
  initial begin : source
    logic       t;
    logic [6:0] req, s1, s2;
    s1 = '0;
    s2 = '0;
    bus.rgb_in = '0;
    forever begin
      @(negedge clk);
      t   = bus.pix_tick;
      req = {bus.pix_x, bus.pix_y};
      @(posedge clk);
      #1;
      if (rst) begin
        s1 = '0;
        s2 = '0;
      end else if (t) begin
        s2 = s1;
        s1 = req;
      end
      bus.rgb_in = src_mode ? 12'hFFF : {s2[6:3], 1'b0, s2[2:0], 4'h5};
    end
  end

  function automatic logic [41:0] expect_vec();
    int h, v, q, qh, qv;
    logic tk, req, ls, fs, hs, vs, vis;
    logic [11:0] rgb;
    h   = m_t % 15;
    v   = (m_t / 15) % 8;
    tk  = !rst && bus.en && (m_div == 1);
    req = (h < 8) && (v < 4);
    ls  = tk && (h == 0);
    fs  = ls && (v == 0);
    hs  = 1'b1;
    vs  = 1'b1;
    vis = 1'b0;
    rgb = '0;
    if (m_t >= 3) begin
      q   = m_t - 3;
      qh  = q % 15;
      qv  = (q / 15) % 8;
      hs  = !(qh >= 10 && qh < 13);
      vs  = !(qv >= 5 && qv < 7);
      vis = (qh < 8) && (qv < 4);
      if (vis) rgb = src_mode ? 12'hFFF : {4'(qh), 1'b0, 3'(qv), 4'h5};
    end
    return {tk, 4'(h), 3'(v), req, ls, fs, hs, vs, vis, rgb, 16'((m_t / 120) % 65536)};
  endfunction

  function automatic logic [41:0] observe();
    return {bus.pix_tick, bus.pix_x, bus.pix_y, bus.pix_req, bus.line_start, bus.frame_start,
            bus.hsync, bus.vsync, bus.vga_visible, bus.vga_r, bus.vga_g, bus.vga_b, bus.frame_cnt};
  endfunction

  // One clock: advance the reference across the edge, then compare at the falling edge.
  task automatic cycle(input string tag);
    logic [41:0] exp_v, obs_v;
    @(posedge clk);
    if (rst) begin
      m_t   = 0;
      m_div = 0;
    end else if (bus.en) begin
      if (m_div == 1) m_t++;
      m_div = (m_div + 1) % 2;
    end
    @(negedge clk);
    exp_v = expect_vec();
    obs_v = observe();
    n_checks++;
    if (obs_v !== exp_v) $display("FAIL %s t=%0d: got %h expected %h", tag, m_t, obs_v, exp_v);
    else n_pass++;
  endtask

  task automatic wait_frame_start(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.frame_start) begin
        found = 1'b1;
        break;
      end
      cycle(tag);
    end
    n_checks++;
    if (!found) $display("FAIL %s: got no frame_start in 300 clks, expected one", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.en   = 1'b1;
    src_mode = 1'b0;
    repeat (3) cycle("reset");
    n_checks++;
    if ({bus.hsync, bus.vsync, bus.vga_visible} !== 3'b110)
      $display("FAIL reset_sync: got %b expected 110", {bus.hsync, bus.vsync, bus.vga_visible});
    else n_pass++;
    n_checks++;
    if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h000)
      $display("FAIL reset_rgb: got %h expected 000", {bus.vga_r, bus.vga_g, bus.vga_b});
    else n_pass++;
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.frame_cnt} !== 23'd0)
      $display("FAIL reset_cnt: got %h expected 0", {bus.pix_x, bus.pix_y, bus.frame_cnt});
    else n_pass++;
    n_checks++;
    if ({bus.pix_tick, bus.line_start, bus.frame_start} !== 3'b000)
      $display("FAIL reset_strobe: got %b expected 000", {bus.pix_tick, bus.line_start, bus.frame_start});
    else n_pass++;
  endtask

  task automatic test_timing();
    int ticks = 0, fs_cnt = 0, fs_bad = 0;
    rst = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      cycle("timing");
      if (bus.pix_tick) ticks++;
      if (bus.frame_start) begin
        fs_cnt++;
        if (k % 240 != 1) fs_bad++;
      end
      if (k == 960) begin
        n_checks++;
        if (bus.frame_cnt !== 16'd4) $display("FAIL frame_cnt_960: got %0d expected 4", bus.frame_cnt);
        else n_pass++;
      end
    end
    n_checks++;
    if (ticks != 500) $display("FAIL tick_count: got %0d expected 500", ticks);
    else n_pass++;
    n_checks++;
    if (fs_cnt != 5 || fs_bad != 0)
      $display("FAIL frame_start_period: got %0d starts (%0d misplaced) expected 5 (0)", fs_cnt, fs_bad);
    else n_pass++;
  endtask

  task automatic test_hsync();
    int hs_low = 0, vs_low = 0, tick_i = 0, first_fall = -1;
    logic prev_hs = 1'b0;
    wait_frame_start("hsync_wait");
    for (int i = 0; i < 240; i++) begin
      if (i > 0) cycle("hsync");
      if (bus.pix_tick) begin
        if (!bus.hsync) hs_low++;
        if (!bus.vsync) vs_low++;
        if (first_fall < 0 && tick_i > 0 && prev_hs && !bus.hsync) first_fall = tick_i;
        prev_hs = bus.hsync;
        tick_i++;
      end
    end
    n_checks++;
    if (hs_low != 24) $display("FAIL hsync_width: got %0d low ticks/frame expected 24", hs_low);
    else n_pass++;
    n_checks++;
    if (vs_low != 30) $display("FAIL vsync_width: got %0d low ticks expected 30", vs_low);
    else n_pass++;
    n_checks++;
    if (first_fall != 13) $display("FAIL hsync_offset: got %0d ticks expected 13", first_fall);
    else n_pass++;
  endtask

  task automatic test_latency();
    int tick_i = 0, first_vis = -1, blank_bad = 0;
    wait_frame_start("lat_wait");
    for (int i = 0; i < 240; i++) begin
      if (i > 0) cycle("latency");
      if (!bus.vga_visible && {bus.vga_r, bus.vga_g, bus.vga_b} != 12'h000) blank_bad++;
      if (bus.pix_tick) begin
        if (first_vis < 0 && bus.vga_visible) begin
          first_vis = tick_i;
          n_checks++;
          if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h005)
            $display("FAIL first_pixel: got %h expected 005", {bus.vga_r, bus.vga_g, bus.vga_b});
          else n_pass++;
        end
        if (tick_i == 8) begin
          n_checks++;
          if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h505)
            $display("FAIL pixel_5_0: got %h expected 505", {bus.vga_r, bus.vga_g, bus.vga_b});
          else n_pass++;
        end
        if (tick_i == 39) begin
          n_checks++;
          if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h625)
            $display("FAIL pixel_6_2: got %h expected 625", {bus.vga_r, bus.vga_g, bus.vga_b});
          else n_pass++;
        end
        tick_i++;
      end
    end
    n_checks++;
    if (first_vis != 3) $display("FAIL latency: got %0d ticks expected 3", first_vis);
    else n_pass++;
    n_checks++;
    if (blank_bad != 0) $display("FAIL blank_rgb: got %0d nonzero blanked clks expected 0", blank_bad);
    else n_pass++;
  endtask

  task automatic test_blank();
    int white = 0, bad = 0;
    rst      = 1'b1;
    src_mode = 1'b1;
    repeat (3) cycle("blank_rst");
    rst = 1'b0;
    cycle("blank");
    wait_frame_start("blank_wait");
    for (int i = 0; i < 240; i++) begin
      if (i > 0) cycle("blank");
      if (bus.pix_tick) begin
        if ({bus.vga_r, bus.vga_g, bus.vga_b} == 12'hFFF) white++;
        else if ({bus.vga_r, bus.vga_g, bus.vga_b} != 12'h000) bad++;
      end
    end
    n_checks++;
    if (white != 32 || bad != 0)
      $display("FAIL blank_force: got %0d white (%0d other) expected 32 (0)", white, bad);
    else n_pass++;
  endtask

  task automatic test_en_pause();
    bit found = 1'b0;
    logic [41:0] snap;
    int frozen_bad = 0;
    for (int i = 0; i < 300; i++) begin
      cycle("pause_wait");
      if (bus.pix_x == 4'd4 && !bus.pix_tick) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) $display("FAIL pause_wait: got no mid-line point in 300 clks, expected one");
    else n_pass++;
    snap   = observe();
    bus.en = 1'b0;
    repeat (37) begin
      cycle("paused");
      if (observe() !== snap) frozen_bad++;
    end
    n_checks++;
    if (frozen_bad != 0) $display("FAIL en_freeze: got %0d changed clks expected 0", frozen_bad);
    else n_pass++;
    bus.en = 1'b1;
    repeat (300) cycle("resume");
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int edges = 0;
    for (int i = 0; i < 300; i++) begin
      cycle("rstmid_wait");
      if (!bus.hsync) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) $display("FAIL rstmid_wait: got no hsync pulse in 300 clks, expected one");
    else n_pass++;
    @(posedge clk);
    #2;
    rst   = 1'b1;
    m_t   = 0;
    m_div = 0;
    #1;
    n_checks++;
    if ({bus.hsync, bus.vsync, bus.vga_visible, bus.vga_r, bus.vga_g, bus.vga_b} !== 15'h6000)
      $display("FAIL rstmid_out: got %h expected 6000",
               {bus.hsync, bus.vsync, bus.vga_visible, bus.vga_r, bus.vga_g, bus.vga_b});
    else n_pass++;
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.frame_cnt, bus.pix_tick} !== 24'd0)
      $display("FAIL rstmid_cnt: got %h expected 0", {bus.pix_x, bus.pix_y, bus.frame_cnt, bus.pix_tick});
    else n_pass++;
    repeat (3) cycle("rstmid_hold");
    rst   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle("rstmid_rel");
      edges++;
      if (bus.frame_start) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found || edges != 1)
      $display("FAIL rstmid_frame_start: got found=%0d after %0d edges expected found=1 after 1", found, edges);
    else n_pass++;
    repeat (250) cycle("rstmid_run");
  endtask

  initial begin
    test_reset();
    test_timing();
    test_hsync();
    test_latency();
    test_blank();
    test_en_pause();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
